mcyc_ctrl_fsm: RTL and testbench
================================

# mcyc_ctrl_fsm

Parametrised multi-cycle control unit for the MIPS32 datapath. It sequences every instruction through fetch/decode/execute/memory/writeback states and drives all datapath register enables and mux selects. It replaces the static opcode decoder with a real state machine that adds:
- variable-latency memory (ready handshake),
- conditional PC write for beq/bne,
- jr support,
- sticky illegal-opcode trap,
- retired-instruction counter.

## Interface
Parameters:
- MEM_HANDSHAKE, 1, when 0 `mem_ready` is ignored and treated as constant 1
- CNTW, 32, width of retired-instruction counter

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- op  in  6  instruction opcode from IR
- funct  in  6  instruction funct field from IR
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes current read/write this cycle
- mem_read / mem_write  out  1  memory strobes
- iord  out  1  address select: 0 = PC, 1 = ALU result register
- ir_write, mdr_write, rega_write, regb_write, alur_write  out  1  register enables
- pc_write  out  1  PC enable, with the branch condition already folded in
- pc_src  out  2  PC source select: 0 ALU, 1 ALU register, 2 jump address, 3 register A
- alu_src_a  out  1  ALU A select: 0 PC, 1 register A
- alu_src_b  out  3  ALU B select: 0 register B, 1 shamt, 2 sign-extended imm, 3 sign-extended imm<<2, 4 constant 4, 5 zero-extended imm
- alu_op  out  4  ALU operation
- reg_write, reg_dst, mem_to_reg  out  1  register-file write control
- instr_done  out  1  one-cycle pulse on the final cycle of each instruction
- instr_count  out  CNTW  retired instructions, wraps modulo 2^CNTW
- illegal  out  1  sticky illegal-opcode flag
- state  out  4  current state, for debug

## Operation
States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC_R, RWB, EXEC_I, IWB, BRANCH, JUMP, JR, TRAP.

Outputs are decoded combinationally from the state, plus `mem_ready` gating. Every output not listed for a state is 0.

- **FETCH:** mem_read=1, iord=0, alu_src_a=0, alu_src_b=4, alu_op=ADD, pc_src=0. On mem_ready: ir_write=1, pc_write=1, go to DECODE; otherwise hold in FETCH.
- **DECODE:** rega_write=1, regb_write=1, alu_src_a=0, alu_src_b=3, ADD, alur_write=1 (branch target). Dispatch on op:
  - 0x23 or 0x2B → MEMADR
  - 0x00 with funct 0x08 → JR; 0x00 otherwise → EXEC_R
  - 0x08, 0x0A, 0x0C, 0x0D → EXEC_I
  - 0x04, 0x05 → BRANCH
  - 0x02 → JUMP
  - anything else → TRAP
- **MEMADR:** alu_src_a=1, alu_src_b=2, ADD, alur_write=1. Go to MEMRD for lw, MEMWR for sw.
- **MEMRD:** iord=1, mem_read=1. On mem_ready: mdr_write=1, go to MEMWB.
- **MEMWB:** reg_write=1, reg_dst=0, mem_to_reg=1, go to FETCH.
- **MEMWR:** iord=1, mem_write=1 until mem_ready, then go to FETCH.
- **EXEC_R:** alu_src_a=1, alur_write=1. By funct:
  - 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x2A SLT: alu_src_b=0
  - 0x00 SLL: alu_src_b=1
  - any other funct → TRAP
  Otherwise go to RWB.
- **RWB:** reg_write=1, reg_dst=1, mem_to_reg=0, go to FETCH.
- **EXEC_I:** alu_src_a=1, alur_write=1:
  - addi: ADD, b=2
  - slti: SLT, b=2
  - andi: AND, b=5
  - ori: OR, b=5
  Go to IWB.
- **IWB:** as RWB but reg_dst=0.
- **BRANCH:** alu_src_a=1, alu_src_b=0, SUB, pc_src=1. pc_write = zero for beq, !zero for bne. Go to FETCH.
- **JUMP:** pc_src=2, pc_write=1, go to FETCH.
- **JR:** pc_src=3, pc_write=1, go to FETCH.
- **TRAP:** all strobes 0. Remains in TRAP until rst. `illegal`=1.
- **Retirement:** `instr_done` is asserted on the last cycle of MEMWB, MEMWR (with ready), RWB, IWB, BRANCH, JUMP and JR. `instr_count` increments on that same edge.
- ALU op codes: AND 0000, OR 0001, ADD 0010, SLL 0011, SUB 0110, SLT 0111.

## Timing
- **Latency** with zero memory wait: beq/bne/j/jr 3 cycles; R-type, I-type and sw 4 cycles; lw 5 cycles.
- **Wait states:** each cycle with mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle. Strobes stay stable while waiting.
- **Reset:**
  - While rst=1, all outputs are 0, including mem_read in FETCH.
  - Reset values: state=FETCH, instr_count=0, illegal=0.
  - Reset asserted mid-instruction abandons it: strobes drop immediately, and no count or write occurs.
- **Counter wrap:** at all-ones + 1 the counter wraps to 0; no flag.
- **Ready outside memory states:** mem_ready arriving outside FETCH, MEMRD or MEMWR is ignored.

## Structure
- Package `mcyc_pkg` holds the state encoding, opcode/funct constants, ALU op codes and the alu_src_b/pc_src select constants. The datapath top imports the same package.
- One sub-module, `mcyc_alu_dec`: combinational funct→(alu_op, alu_src_b, legal) decoder, used in EXEC_R.

## Test plan
- **add (op 0x00, funct 0x20), mem_ready=1:** states FETCH→DECODE→EXEC_R→RWB; reg_write=1 and reg_dst=1 in cycle 4; instr_count=1.
- **lw (0x23) with mem_ready low for 2 cycles in MEMRD:** 7 cycles total; mdr_write pulses once; reg_write with mem_to_reg=1.
- **beq (0x04):** zero=1 gives pc_write=1 and pc_src=1 in BRANCH; zero=0 gives pc_write=0. bne (0x05) gives the inverse.
- **op 0x3F:** enters TRAP after DECODE; illegal=1 persists; counter frozen. rst=1 clears illegal and returns to FETCH.
- **rst asserted during MEMWR:** mem_write drops in the same cycle; after release, FETCH with instr_count unchanged.
- **CNTW=4, 16 jumps (0x02):** instr_count wraps to 0; each jump takes 3 cycles with pc_src=2.

Source files
------------

// File: rtl/mcyc_pkg.sv
// Shared encodings for the multi-cycle MIPS32 control unit: states, opcodes, functs, ALU ops, mux selects.
// Pure declarations; no timing or flow control of its own.
package mcyc_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC_R = 4'd6,
        S_RWB    = 4'd7,
        S_EXEC_I = 4'd8,
        S_IWB    = 4'd9,
        S_BRANCH = 4'd10,
        S_JUMP   = 4'd11,
        S_JR     = 4'd12,
        S_TRAP   = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SLL = 4'b0011;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    localparam logic [2:0] SRCB_REGB    = 3'd0;
    localparam logic [2:0] SRCB_SHAMT   = 3'd1;
    localparam logic [2:0] SRCB_IMM     = 3'd2;
    localparam logic [2:0] SRCB_IMM_SH2 = 3'd3;
    localparam logic [2:0] SRCB_FOUR    = 3'd4;
    localparam logic [2:0] SRCB_ZIMM    = 3'd5;

    localparam logic [1:0] PCSRC_ALU  = 2'd0;
    localparam logic [1:0] PCSRC_ALUR = 2'd1;
    localparam logic [1:0] PCSRC_JUMP = 2'd2;
    localparam logic [1:0] PCSRC_REGA = 2'd3;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       ir_write;
        logic       mdr_write;
        logic       rega_write;
        logic       regb_write;
        logic       alur_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [2:0] alu_src_b;
        logic [3:0] alu_op;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       instr_done;
    } ctrl_t;

    // DECODE-state dispatch; unknown opcodes fall into the trap
    function automatic state_t dispatch(input logic [5:0] op, input logic [5:0] funct);
        state_t s;
        s = S_TRAP;
        case (op)
            OP_LW, OP_SW:                       s = S_MEMADR;
            OP_RTYPE:                           s = (funct == FN_JR) ? S_JR : S_EXEC_R;
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI:  s = S_EXEC_I;
            OP_BEQ, OP_BNE:                     s = S_BRANCH;
            OP_J:                               s = S_JUMP;
            default:                            s = S_TRAP;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/mcyc_alu_dec.sv
// R-type funct decoder: ALU op, B-operand select and legality for EXEC_R.
// Purely combinational, zero latency, no flow control.
module mcyc_alu_dec
    import mcyc_pkg::*;
(
    input  logic [5:0] funct,
    output logic [3:0] alu_op,
    output logic [2:0] alu_src_b,
    output logic       legal
);

    always_comb begin
        alu_op    = ALU_ADD;
        alu_src_b = SRCB_REGB;
        legal     = 1'b1;
        case (funct)
            FN_ADD:  alu_op = ALU_ADD;
            FN_SUB:  alu_op = ALU_SUB;
            FN_AND:  alu_op = ALU_AND;
            FN_OR:   alu_op = ALU_OR;
            FN_SLT:  alu_op = ALU_SLT;
            FN_SLL: begin
                alu_op    = ALU_SLL;
                alu_src_b = SRCB_SHAMT;
            end
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/mcyc_ctrl_fsm.sv
// Multi-cycle MIPS32 control FSM: 3 cycles for branch/jump, 4 for R/I/sw, 5 for lw with zero wait.
// FETCH/MEMRD/MEMWR stall with strobes held while mem_ready is low; all outputs forced to 0 during reset.
module mcyc_ctrl_fsm
    import mcyc_pkg::*;
#(
    parameter bit MEM_HANDSHAKE = 1'b1,
    parameter int CNTW          = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [5:0]      op,
    input  logic [5:0]      funct,
    input  logic            zero,
    input  logic            mem_ready,
    output logic            mem_read,
    output logic            mem_write,
    output logic            iord,
    output logic            ir_write,
    output logic            mdr_write,
    output logic            rega_write,
    output logic            regb_write,
    output logic            alur_write,
    output logic            pc_write,
    output logic [1:0]      pc_src,
    output logic            alu_src_a,
    output logic [2:0]      alu_src_b,
    output logic [3:0]      alu_op,
    output logic            reg_write,
    output logic            reg_dst,
    output logic            mem_to_reg,
    output logic            instr_done,
    output logic [CNTW-1:0] instr_count,
    output logic            illegal,
    output logic [3:0]      state
);

    state_t          cur, nxt;
    ctrl_t           c, co;
    logic            ready;
    logic [CNTW-1:0] cnt;
    logic [3:0]      r_alu_op;
    logic [2:0]      r_srcb;
    logic            r_legal;

    assign ready = MEM_HANDSHAKE ? mem_ready : 1'b1;

    mcyc_alu_dec u_alu_dec (
        .funct     (funct),
        .alu_op    (r_alu_op),
        .alu_src_b (r_srcb),
        .legal     (r_legal)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur <= S_FETCH;
            cnt <= '0;
        end else begin
            cur <= nxt;
            if (c.instr_done)
                cnt <= cnt + CNTW'(1);
        end
    end

    always_comb begin
        c   = '0;
        nxt = cur;
        case (cur)
            S_FETCH: begin
                c.mem_read  = 1'b1;
                c.alu_src_b = SRCB_FOUR;
                c.alu_op    = ALU_ADD;
                c.pc_src    = PCSRC_ALU;
                if (ready) begin
                    c.ir_write = 1'b1;
                    c.pc_write = 1'b1;
                    nxt        = S_DECODE;
                end
            end
            S_DECODE: begin
                // ALU precomputes the branch target while the register file is read
                c.rega_write = 1'b1;
                c.regb_write = 1'b1;
                c.alu_src_b  = SRCB_IMM_SH2;
                c.alu_op     = ALU_ADD;
                c.alur_write = 1'b1;
                nxt          = dispatch(op, funct);
            end
            S_MEMADR: begin
                c.alu_src_a  = 1'b1;
                c.alu_src_b  = SRCB_IMM;
                c.alu_op     = ALU_ADD;
                c.alur_write = 1'b1;
                nxt          = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                c.iord     = 1'b1;
                c.mem_read = 1'b1;
                if (ready) begin
                    c.mdr_write = 1'b1;
                    nxt         = S_MEMWB;
                end
            end
            S_MEMWB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
                c.instr_done = 1'b1;
                nxt          = S_FETCH;
            end
            S_MEMWR: begin
                c.iord      = 1'b1;
                c.mem_write = 1'b1;
                if (ready) begin
                    c.instr_done = 1'b1;
                    nxt          = S_FETCH;
                end
            end
            S_EXEC_R: begin
                c.alu_src_a  = 1'b1;
                c.alur_write = 1'b1;
                c.alu_op     = r_alu_op;
                c.alu_src_b  = r_srcb;
                nxt          = r_legal ? S_RWB : S_TRAP;
            end
            S_RWB: begin
                c.reg_write  = 1'b1;
                c.reg_dst    = 1'b1;
                c.instr_done = 1'b1;
                nxt          = S_FETCH;
            end
            S_EXEC_I: begin
                c.alu_src_a  = 1'b1;
                c.alur_write = 1'b1;
                case (op)
                    OP_ADDI: begin c.alu_op = ALU_ADD; c.alu_src_b = SRCB_IMM;  end
                    OP_SLTI: begin c.alu_op = ALU_SLT; c.alu_src_b = SRCB_IMM;  end
                    OP_ANDI: begin c.alu_op = ALU_AND; c.alu_src_b = SRCB_ZIMM; end
                    OP_ORI:  begin c.alu_op = ALU_OR;  c.alu_src_b = SRCB_ZIMM; end
                    default: ;
                endcase
                nxt = S_IWB;
            end
            S_IWB: begin
                c.reg_write  = 1'b1;
                c.instr_done = 1'b1;
                nxt          = S_FETCH;
            end
            S_BRANCH: begin
                c.alu_src_a  = 1'b1;
                c.alu_src_b  = SRCB_REGB;
                c.alu_op     = ALU_SUB;
                c.pc_src     = PCSRC_ALUR;
                c.pc_write   = (op == OP_BNE) ? ~zero : zero;
                c.instr_done = 1'b1;
                nxt          = S_FETCH;
            end
            S_JUMP: begin
                c.pc_src     = PCSRC_JUMP;
                c.pc_write   = 1'b1;
                c.instr_done = 1'b1;
                nxt          = S_FETCH;
            end
            S_JR: begin
                c.pc_src     = PCSRC_REGA;
                c.pc_write   = 1'b1;
                c.instr_done = 1'b1;
                nxt          = S_FETCH;
            end
            S_TRAP:  nxt = S_TRAP;
            default: nxt = S_FETCH;
        endcase
    end

    // Reset masks everything combinationally so an abandoned instruction drops its strobes at once
    assign co = rst ? '0 : c;

    assign mem_read    = co.mem_read;
    assign mem_write   = co.mem_write;
    assign iord        = co.iord;
    assign ir_write    = co.ir_write;
    assign mdr_write   = co.mdr_write;
    assign rega_write  = co.rega_write;
    assign regb_write  = co.regb_write;
    assign alur_write  = co.alur_write;
    assign pc_write    = co.pc_write;
    assign pc_src      = co.pc_src;
    assign alu_src_a   = co.alu_src_a;
    assign alu_src_b   = co.alu_src_b;
    assign alu_op      = co.alu_op;
    assign reg_write   = co.reg_write;
    assign reg_dst     = co.reg_dst;
    assign mem_to_reg  = co.mem_to_reg;
    assign instr_done  = co.instr_done;
    assign instr_count = cnt;
    assign illegal     = ~rst & (cur == S_TRAP);
    assign state       = rst ? 4'd0 : cur;

endmodule

// File: tb/tb_mcyc_ctrl_fsm.sv
// Directed bench for mcyc_ctrl_fsm with a 4-bit retired counter so the wrap is reachable.
module tb_mcyc_ctrl_fsm;

    localparam logic [3:0] ST_FETCH = 4'd0,  ST_DECODE = 4'd1, ST_MEMADR = 4'd2, ST_MEMRD = 4'd3;
    localparam logic [3:0] ST_MEMWB = 4'd4,  ST_MEMWR = 4'd5,  ST_EXEC_R = 4'd6, ST_RWB   = 4'd7;
    localparam logic [3:0] ST_EXEC_I = 4'd8, ST_BRANCH = 4'd10, ST_TRAP = 4'd13;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] op = 6'h00, funct = 6'h00;
    logic       zero = 1'b0, mem_ready = 1'b1;
    logic       mem_read, mem_write, iord, ir_write, mdr_write, rega_write, regb_write, alur_write;
    logic       pc_write, alu_src_a, reg_write, reg_dst, mem_to_reg, instr_done, illegal;
    logic [1:0] pc_src;
    logic [2:0] alu_src_b;
    logic [3:0] alu_op, instr_count, state;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;

    int         r_cyc, r_mdr;
    logic [3:0] r_alu_op, r_last_st;
    logic [2:0] r_srcb;
    logic [1:0] r_pcsrc;
    logic       r_regw, r_regdst, r_m2r, r_pcw;

    mcyc_ctrl_fsm #(.MEM_HANDSHAKE(1'b1), .CNTW(4)) dut (
        .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .mem_read(mem_read), .mem_write(mem_write), .iord(iord), .ir_write(ir_write),
        .mdr_write(mdr_write), .rega_write(rega_write), .regb_write(regb_write),
        .alur_write(alur_write), .pc_write(pc_write), .pc_src(pc_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_write(reg_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .instr_done(instr_done), .instr_count(instr_count),
        .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one instruction from FETCH to its retiring cycle; mem_ready is held low for
    // 'waits' cycles once a data-memory state is reached.
    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z, input int waits);
        int w;
        bit done;
        w = 0;
        done = 1'b0;
        r_cyc = 0;
        r_mdr = 0;
        r_alu_op = '0;
        r_srcb = '0;
        op = o;
        funct = f;
        zero = z;
        while (!done && r_cyc < 30) begin
            mem_ready = ((state == ST_MEMRD || state == ST_MEMWR) && w < waits) ? 1'b0 : 1'b1;
            if (!mem_ready) w++;
            #1;
            r_cyc++;
            r_mdr += int'(mdr_write);
            if (state == ST_EXEC_R || state == ST_EXEC_I) begin
                r_alu_op = alu_op;
                r_srcb = alu_src_b;
            end
            r_regw = reg_write;
            r_regdst = reg_dst;
            r_m2r = mem_to_reg;
            r_pcw = pc_write;
            r_pcsrc = pc_src;
            r_last_st = state;
            done = instr_done;
            step();
        end
        mem_ready = 1'b1;
        chk("retired", 32'(done), 1);
        exp_cnt = (exp_cnt + 1) % 16;
        chk("count", 32'(instr_count), exp_cnt);
    endtask

    initial begin
        // Reset: outputs held at 0 even though the FSM sits in FETCH
        step();
        step();
        chk("rst_state", 32'(state), ST_FETCH);
        chk("rst_mem_read", 32'(mem_read), 0);
        chk("rst_count", 32'(instr_count), 0);
        chk("rst_illegal", 32'(illegal), 0);
        chk("rst_pc_write", 32'(pc_write), 0);
        rst = 1'b0;
        #1;
        chk("post_rst_mem_read", 32'(mem_read), 1);

        // Reset asserted while sw waits in MEMWR
        op = 6'h2B;
        step();
        step();
        step();
        mem_ready = 1'b0;
        #1;
        chk("memwr_state", 32'(state), ST_MEMWR);
        chk("memwr_write", 32'(mem_write), 1);
        chk("memwr_iord", 32'(iord), 1);
        step();
        chk("memwr_hold", 32'(mem_write), 1);
        rst = 1'b1;
        #1;
        chk("rst_drop_write", 32'(mem_write), 0);
        chk("rst_drop_done", 32'(instr_done), 0);
        step();
        rst = 1'b0;
        mem_ready = 1'b1;
        #1;
        chk("rst_memwr_state", 32'(state), ST_FETCH);
        chk("rst_memwr_count", 32'(instr_count), 0);

        // add, cycle by cycle
        op = 6'h00;
        funct = 6'h20;
        #1;
        chk("add_c1_state", 32'(state), ST_FETCH);
        chk("add_c1_ir_write", 32'(ir_write), 1);
        chk("add_c1_pc_write", 32'(pc_write), 1);
        chk("add_c1_srcb", 32'(alu_src_b), 4);
        chk("add_c1_aluop", 32'(alu_op), 4'b0010);
        step();
        chk("add_c2_state", 32'(state), ST_DECODE);
        chk("add_c2_rega", 32'(rega_write), 1);
        chk("add_c2_srcb", 32'(alu_src_b), 3);
        step();
        chk("add_c3_state", 32'(state), ST_EXEC_R);
        chk("add_c3_srca", 32'(alu_src_a), 1);
        chk("add_c3_srcb", 32'(alu_src_b), 0);
        chk("add_c3_reg_write", 32'(reg_write), 0);
        step();
        chk("add_c4_state", 32'(state), ST_RWB);
        chk("add_c4_reg_write", 32'(reg_write), 1);
        chk("add_c4_reg_dst", 32'(reg_dst), 1);
        chk("add_c4_done", 32'(instr_done), 1);
        step();
        exp_cnt = 1;
        chk("add_count", 32'(instr_count), exp_cnt);

        // FETCH wait states hold strobes and block the IR load
        op = 6'h02;
        mem_ready = 1'b0;
        #1;
        chk("fwait_mem_read", 32'(mem_read), 1);
        chk("fwait_ir_write", 32'(ir_write), 0);
        chk("fwait_pc_write", 32'(pc_write), 0);
        step();
        chk("fwait_state", 32'(state), ST_FETCH);
        run_instr(6'h02, 6'h00, 1'b0, 0);
        chk("j_cycles", r_cyc, 3);

        run_instr(6'h23, 6'h00, 1'b0, 2);
        chk("lw_cycles", r_cyc, 7);
        chk("lw_mdr_pulses", r_mdr, 1);
        chk("lw_last_state", 32'(r_last_st), ST_MEMWB);
        chk("lw_reg_write", 32'(r_regw), 1);
        chk("lw_mem_to_reg", 32'(r_m2r), 1);

        run_instr(6'h2B, 6'h00, 1'b0, 0);
        chk("sw_cycles", r_cyc, 4);
        run_instr(6'h2B, 6'h00, 1'b0, 1);
        chk("sw_wait_cycles", r_cyc, 5);

        run_instr(6'h04, 6'h00, 1'b1, 0);
        chk("beq_t_cycles", r_cyc, 3);
        chk("beq_t_state", 32'(r_last_st), ST_BRANCH);
        chk("beq_t_pcw", 32'(r_pcw), 1);
        chk("beq_t_pcsrc", 32'(r_pcsrc), 1);
        run_instr(6'h04, 6'h00, 1'b0, 0);
        chk("beq_nt_pcw", 32'(r_pcw), 0);
        run_instr(6'h05, 6'h00, 1'b0, 0);
        chk("bne_t_pcw", 32'(r_pcw), 1);
        run_instr(6'h05, 6'h00, 1'b1, 0);
        chk("bne_nt_pcw", 32'(r_pcw), 0);

        run_instr(6'h08, 6'h00, 1'b0, 0);
        chk("addi_cycles", r_cyc, 4);
        chk("addi_reg_dst", 32'(r_regdst), 0);
        chk("addi_reg_write", 32'(r_regw), 1);
        chk("addi_aluop", 32'(r_alu_op), 4'b0010);
        chk("addi_srcb", 32'(r_srcb), 2);
        run_instr(6'h0A, 6'h00, 1'b0, 0);
        chk("slti_aluop", 32'(r_alu_op), 4'b0111);
        run_instr(6'h0C, 6'h00, 1'b0, 0);
        chk("andi_aluop", 32'(r_alu_op), 4'b0000);
        chk("andi_srcb", 32'(r_srcb), 5);
        run_instr(6'h0D, 6'h00, 1'b0, 0);
        chk("ori_aluop", 32'(r_alu_op), 4'b0001);

        run_instr(6'h00, 6'h22, 1'b0, 0);
        chk("sub_aluop", 32'(r_alu_op), 4'b0110);
        chk("sub_reg_dst", 32'(r_regdst), 1);
        run_instr(6'h00, 6'h25, 1'b0, 0);
        chk("or_aluop", 32'(r_alu_op), 4'b0001);
        run_instr(6'h00, 6'h2A, 1'b0, 0);
        chk("slt_aluop", 32'(r_alu_op), 4'b0111);
        run_instr(6'h00, 6'h00, 1'b0, 0);
        chk("sll_aluop", 32'(r_alu_op), 4'b0011);
        chk("sll_srcb", 32'(r_srcb), 1);

        run_instr(6'h00, 6'h08, 1'b0, 0);
        chk("jr_cycles", r_cyc, 3);
        chk("jr_pcsrc", 32'(r_pcsrc), 3);
        chk("jr_pcw", 32'(r_pcw), 1);

        // 16 jumps walk the 4-bit counter through its wrap
        for (int i = 0; i < 16; i++) begin
            run_instr(6'h02, 6'h00, 1'b0, 0);
            chk("jmp_cycles", r_cyc, 3);
            chk("jmp_pcsrc", 32'(r_pcsrc), 2);
        end

        // Illegal opcode: sticky trap, counter frozen, cleared only by reset
        op = 6'h3F;
        step();
        chk("trap_decode", 32'(state), ST_DECODE);
        step();
        for (int i = 0; i < 4; i++) begin
            chk("trap_state", 32'(state), ST_TRAP);
            chk("trap_illegal", 32'(illegal), 1);
            chk("trap_mem_read", 32'(mem_read), 0);
            chk("trap_count", 32'(instr_count), exp_cnt);
            step();
        end
        rst = 1'b1;
        #1;
        chk("trap_rst_illegal", 32'(illegal), 0);
        chk("trap_rst_state", 32'(state), ST_FETCH);
        step();
        rst = 1'b0;
        exp_cnt = 0;
        #1;
        chk("trap_rst_count", 32'(instr_count), exp_cnt);

        // Unsupported R-type funct traps out of EXEC_R
        op = 6'h00;
        funct = 6'h3F;
        step();
        step();
        chk("bad_fn_exec", 32'(state), ST_EXEC_R);
        step();
        chk("bad_fn_trap", 32'(state), ST_TRAP);
        chk("bad_fn_illegal", 32'(illegal), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
